// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path.
//   - data / result widths and register-index width
//   - ALU opcode encoding (same codes the ALU decodes)
//   - sequencer state encoding
//   - next_reg(): register index + 1, wrapping 3 -> 0
package alu_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned RES_W     = 8;
  localparam int unsigned REG_IDX_W = 2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_ROL  = 4'b1101;
  localparam logic [3:0] OP_ROR  = 4'b1110;
  localparam logic [3:0] OP_ASR  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } seq_state_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Index arithmetic is modulo the register count by construction.
  function automatic reg_idx_t next_reg(input reg_idx_t idx);
    return idx + reg_idx_t'(1);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Local operand register file: NUM_REGS x DATA_W bits.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (clears all entries)
//   ra_a / rd_a          combinational read port A
//   ra_b / rd_b          combinational read port B
//   dbg_sel / dbg_data   combinational debug read port
//   we0 / wa0 / wd0      write port 0 (load or ALU low nibble)
//   we1 / wa1 / wd1      write port 1 (multiply high nibble); wins on address clash
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_idx_t          ra_a,
  output logic [DATA_W-1:0] rd_a,
  input  reg_idx_t          ra_b,
  output logic [DATA_W-1:0] rd_b,
  input  reg_idx_t          dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we0,
  input  reg_idx_t          wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  reg_idx_t          wa1,
  input  logic [DATA_W-1:0] wd1
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reads return the pre-write contents within a cycle.
  assign rd_a     = regs[ra_a];
  assign rd_b     = regs[ra_b];
  assign dbg_data = regs[dbg_sel];

  // NOTE: this small array lives in flops, so it is cleared by reset like any
  // other state; a RAM macro could not be reset this way.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[wa0] <= wd0;
      if (we1) regs[wa1] <= wd1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side controller for the 4-bit combinational ALU.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_load, cmd_dst,
//   cmd_src_a, cmd_src_b,
//   cmd_use_imm, cmd_imm          command fields
//   alu_a / alu_b / alu_opcode    registered ALU inputs, held between issues
//   alu_result/alu_carry/alu_rem  ALU outputs, sampled only in CAPTURE
//   rsp_valid / rsp_ready         response handshake
//   rsp_result/carry/rem/err      registered response fields
//   dbg_sel / dbg_data            combinational register-file peek
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned NUM_REGS      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              cmd_load,
  input  reg_idx_t          cmd_dst,
  input  reg_idx_t          cmd_src_a,
  input  reg_idx_t          cmd_src_b,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_carry,
  input  logic [DATA_W-1:0] alu_rem,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_carry,
  output logic [DATA_W-1:0] rsp_rem,
  output logic              rsp_err,
  input  reg_idx_t          dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  seq_state_e        state;
  logic [3:0]        settle_cnt;
  reg_idx_t          dst_q;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] opnd_b;
  logic              accept;
  logic              div_by_zero;

  logic              we0;
  reg_idx_t          wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  reg_idx_t          wa1;
  logic [DATA_W-1:0] wd1;

  alu_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_a     (cmd_src_a),
    .rd_a     (rd_a),
    .ra_b     (cmd_src_b),
    .rd_b     (rd_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1)
  );

  assign opnd_b      = cmd_use_imm ? cmd_imm : rd_b;
  assign accept      = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign div_by_zero = (cmd_op == OP_DIV) && (opnd_b == '0);

  // Write port 0 serves both an accepted load (IDLE) and the ALU writeback
  // (CAPTURE); the two never coincide. Port 1 carries the multiply high nibble.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    we0 = 1'b0;
    wa0 = cmd_dst;
    wd0 = cmd_imm;
    we1 = 1'b0;
    wa1 = next_reg(dst_q);
    wd1 = alu_result[7:4];
    if (state == ST_CAPTURE) begin
      we0 = 1'b1;
      wa0 = dst_q;
      wd0 = alu_result[3:0];
      we1 = (alu_opcode == OP_MUL);
    end else if (accept && cmd_load) begin
      we0 = 1'b1;
    end
  end

  // cmd_ready is registered: it stays low through reset and rises on the first
  // edge after release, and drops on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      settle_cnt <= '0;
      dst_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_rem    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            dst_q     <= cmd_dst;
            if (cmd_load) begin
              rsp_result <= {4'h0, cmd_imm};
              rsp_carry  <= 1'b0;
              rsp_rem    <= '0;
              rsp_err    <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end else if (div_by_zero) begin
              // Rejected without touching the ALU inputs or the register file.
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_rem    <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end else begin
              alu_a      <= rd_a;
              alu_b      <= opnd_b;
              alu_opcode <= cmd_op;
              settle_cnt <= 4'(SETTLE_CYCLES);
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          settle_cnt <= settle_cnt - 4'd1;
          // <= 1 rather than == 1 so an out-of-range count cannot stall here.
          if (settle_cnt <= 4'd1) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_rem    <= alu_rem;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer. Two instances: u_dut1 (SETTLE_CYCLES=1)
// and u_dut4 (SETTLE_CYCLES=4); 'sel' routes stimulus/observation to one.
// Each instance drives a small behavioural ALU standing in for the real one.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       cmd_valid;
  logic       rsp_ready;
  logic [3:0] cmd_op;
  logic       cmd_load;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic       cmd_use_imm;
  logic [3:0] cmd_imm;
  logic [1:0] dbg_sel;

  int n_checks = 0;
  int n_errors = 0;
  int hs1      = 0;
  int lat;

  logic       cmd_ready1, cmd_ready4;
  logic [3:0] alu_a1, alu_b1, alu_op1, alu_a4, alu_b4, alu_op4;
  logic [7:0] alu_res1, alu_res4;
  logic       alu_carry1, alu_carry4;
  logic [3:0] alu_rem1, alu_rem4;
  logic       rsp_valid1, rsp_valid4;
  logic [7:0] rsp_result1, rsp_result4;
  logic       rsp_carry1, rsp_carry4;
  logic [3:0] rsp_rem1, rsp_rem4;
  logic       rsp_err1, rsp_err4;
  logic [3:0] dbg_data1, dbg_data4;

  always #5 clk = ~clk;

  // Stand-in ALU: returns {rem, carry, result}.
  function automatic logic [12:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] op);
    logic [4:0] s;
    logic [7:0] r;
    logic       c;
    logic [3:0] m;
    r = '0;
    c = 1'b0;
    m = '0;
    s = '0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = {3'b0, s}; c = s[4]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = {4'h0, s[3:0]}; c = s[4]; end
      OP_MUL: r = {4'h0, a} * {4'h0, b};
      OP_DIV: if (b != 4'h0) begin r = {4'h0, a / b}; m = a % b; end
      OP_AND: r = {4'h0, a & b};
      OP_OR:  r = {4'h0, a | b};
      OP_XOR: r = {4'h0, a ^ b};
      default: ;
    endcase
    return {m, c, r};
  endfunction

  assign {alu_rem1, alu_carry1, alu_res1} = alu_model(alu_a1, alu_b1, alu_op1);
  assign {alu_rem4, alu_carry4, alu_res4} = alu_model(alu_a4, alu_b4, alu_op4);

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .NUM_REGS(4)) u_dut1 (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid & ~sel), .cmd_ready (cmd_ready1),
    .cmd_op (cmd_op), .cmd_load (cmd_load), .cmd_dst (cmd_dst),
    .cmd_src_a (cmd_src_a), .cmd_src_b (cmd_src_b),
    .cmd_use_imm (cmd_use_imm), .cmd_imm (cmd_imm),
    .alu_a (alu_a1), .alu_b (alu_b1), .alu_opcode (alu_op1),
    .alu_result (alu_res1), .alu_carry (alu_carry1), .alu_rem (alu_rem1),
    .rsp_valid (rsp_valid1), .rsp_ready (rsp_ready & ~sel),
    .rsp_result (rsp_result1), .rsp_carry (rsp_carry1), .rsp_rem (rsp_rem1),
    .rsp_err (rsp_err1), .dbg_sel (dbg_sel), .dbg_data (dbg_data1)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(4), .NUM_REGS(4)) u_dut4 (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid & sel), .cmd_ready (cmd_ready4),
    .cmd_op (cmd_op), .cmd_load (cmd_load), .cmd_dst (cmd_dst),
    .cmd_src_a (cmd_src_a), .cmd_src_b (cmd_src_b),
    .cmd_use_imm (cmd_use_imm), .cmd_imm (cmd_imm),
    .alu_a (alu_a4), .alu_b (alu_b4), .alu_opcode (alu_op4),
    .alu_result (alu_res4), .alu_carry (alu_carry4), .alu_rem (alu_rem4),
    .rsp_valid (rsp_valid4), .rsp_ready (rsp_ready & sel),
    .rsp_result (rsp_result4), .rsp_carry (rsp_carry4), .rsp_rem (rsp_rem4),
    .rsp_err (rsp_err4), .dbg_sel (dbg_sel), .dbg_data (dbg_data4)
  );

  // Views of whichever instance is selected.
  logic       cmd_ready_s, rsp_valid_s, rsp_carry_s, rsp_err_s;
  logic [3:0] alu_a_s, alu_b_s, alu_op_s, rsp_rem_s, dbg_data_s;
  logic [7:0] rsp_result_s;
  assign cmd_ready_s  = sel ? cmd_ready4  : cmd_ready1;
  assign rsp_valid_s  = sel ? rsp_valid4  : rsp_valid1;
  assign rsp_carry_s  = sel ? rsp_carry4  : rsp_carry1;
  assign rsp_err_s    = sel ? rsp_err4    : rsp_err1;
  assign rsp_rem_s    = sel ? rsp_rem4    : rsp_rem1;
  assign rsp_result_s = sel ? rsp_result4 : rsp_result1;
  assign alu_a_s      = sel ? alu_a4      : alu_a1;
  assign alu_b_s      = sel ? alu_b4      : alu_b1;
  assign alu_op_s     = sel ? alu_op4     : alu_op1;
  assign dbg_data_s   = sel ? dbg_data4   : dbg_data1;

  // Response handshakes seen by u_dut1.
  always @(posedge clk) if (!rst && rsp_valid1 && rsp_ready && !sel) hs1++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data_s, exp);
  endtask

  // Present a command on a falling edge and hold it through the accepting edge.
  task automatic drive_cmd(input logic ld, input logic [3:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic ui, input logic [3:0] imm);
    @(negedge clk);
    cmd_load = ld; cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
    cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
    check("cmd_ready_before_accept", cmd_ready_s, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Latency in clock edges from the accepting edge to rsp_valid (bounded).
  task automatic wait_rsp(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!rsp_valid_s && l < 40);
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input int exp_lat, input logic [7:0] res,
                           input logic c, input logic [3:0] rem, input logic err);
    wait_rsp(lat);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"},  rsp_result_s, res);
    check({tag, ".carry"},   rsp_carry_s, c);
    check({tag, ".rem"},     rsp_rem_s, rem);
    check({tag, ".err"},     rsp_err_s, err);
    take_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; dbg_sel = '0;
    cmd_op = '0; cmd_load = 1'b0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
    cmd_use_imm = 1'b0; cmd_imm = '0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("reset.cmd_ready", cmd_ready1, 1'b0);
    check("reset.rsp_valid", rsp_valid1, 1'b0);
    check("reset.alu_opcode", alu_op1, 4'h0);
    check("reset.rsp_result", rsp_result1, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset.cmd_ready", cmd_ready1, 1'b1);

    // Load and add.
    drive_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 4'h6);
    check_rsp("load_r0", 1, 8'h06, 1'b0, 4'h0, 1'b0);
    drive_cmd(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 4'h3);
    check_rsp("load_r1", 1, 8'h03, 1'b0, 4'h0, 1'b0);
    drive_cmd(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0);
    check_rsp("add", 3, 8'h09, 1'b0, 4'h0, 1'b0);
    check_reg("add.r2", 2'd2, 4'h9);

    // Multiply with high-nibble wrap into R0.
    drive_cmd(1'b1, OP_ADD, 2'd3, 2'd0, 2'd0, 1'b0, 4'hF);
    check_rsp("load_r3", 1, 8'h0F, 1'b0, 4'h0, 1'b0);
    drive_cmd(1'b0, OP_MUL, 2'd3, 2'd3, 2'd3, 1'b0, 4'h0);
    check_rsp("mul", 3, 8'hE1, 1'b0, 4'h0, 1'b0);
    check_reg("mul.r3", 2'd3, 4'h1);
    check_reg("mul.r0", 2'd0, 4'hE);

    // Divide by zero: rejected, nothing issued or written.
    drive_cmd(1'b0, OP_DIV, 2'd0, 2'd0, 2'd0, 1'b1, 4'h0);
    check_rsp("div0", 1, 8'h00, 1'b0, 4'h0, 1'b1);
    check("div0.alu_opcode", alu_op_s, OP_MUL);
    check_reg("div0.r0", 2'd0, 4'hE);
    check_reg("div0.r1", 2'd1, 4'h3);
    check_reg("div0.r2", 2'd2, 4'h9);
    check_reg("div0.r3", 2'd3, 4'h1);

    // 7 / 2 = 3 rem 1.
    drive_cmd(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 4'h7);
    check_rsp("load_r1_7", 1, 8'h07, 1'b0, 4'h0, 1'b0);
    drive_cmd(1'b0, OP_DIV, 2'd2, 2'd1, 2'd0, 1'b1, 4'h2);
    check_rsp("div", 3, 8'h03, 1'b0, 4'h1, 1'b0);
    check_reg("div.r2", 2'd2, 4'h3);

    // Backpressure: R2(3) + R3(1) -> R0, response held for 5 cycles while a
    // competing load to R2 is presented.
    drive_cmd(1'b0, OP_ADD, 2'd0, 2'd2, 2'd3, 1'b0, 4'h0);
    wait_rsp(lat);
    check("bp.latency", lat, 3);
    hs_before = hs1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cmd_load = 1'b1; cmd_dst = 2'd2; cmd_imm = 4'hF; cmd_valid = 1'b1;
      end
      check("bp.rsp_valid", rsp_valid_s, 1'b1);
      check("bp.rsp_result", rsp_result_s, 8'h04);
      check("bp.cmd_ready", cmd_ready_s, 1'b0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp.rsp_valid_drop", rsp_valid_s, 1'b0);
    check("bp.cmd_ready_back", cmd_ready_s, 1'b1);
    repeat (3) @(negedge clk);
    check("bp.handshakes", hs1 - hs_before, 1);
    check_reg("bp.r2_unchanged", 2'd2, 4'h3);
    check_reg("bp.r0", 2'd0, 4'h4);

    // Add with carry out: 7 + F = 0x16.
    drive_cmd(1'b0, OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 4'hF);
    check_rsp("add_carry", 3, 8'h16, 1'b1, 4'h0, 1'b0);
    check_reg("add_carry.r1", 2'd1, 4'h6);

    // Settle time of 4 on the second instance.
    sel = 1'b1;
    drive_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 4'h5);
    check_rsp("s4.load_r0", 1, 8'h05, 1'b0, 4'h0, 1'b0);
    drive_cmd(1'b0, OP_SUB, 2'd1, 2'd0, 2'd0, 1'b1, 4'h2);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("s4.alu_a_hold", alu_a_s, 4'h5);
      check("s4.alu_b_hold", alu_b_s, 4'h2);
      check("s4.alu_op_hold", alu_op_s, OP_SUB);
      check("s4.no_early_rsp", rsp_valid_s, 1'b0);
    end
    @(negedge clk);
    check("s4.rsp_valid_at_6", rsp_valid_s, 1'b1);
    check("s4.result", rsp_result_s, 8'h03);
    check("s4.carry", rsp_carry_s, 1'b0);
    take_rsp();
    check_reg("s4.r1", 2'd1, 4'h3);

    // Reset during ISSUE of SUB dst=1 (5 - 2): aborted, R1 left cleared.
    drive_cmd(1'b0, OP_SUB, 2'd1, 2'd0, 2'd0, 1'b1, 4'h2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.alu_a", alu_a_s, 4'h0);
    check("rst_mid.alu_b", alu_b_s, 4'h0);
    check("rst_mid.alu_opcode", alu_op_s, 4'h0);
    check("rst_mid.rsp_valid", rsp_valid_s, 1'b0);
    check("rst_mid.cmd_ready", cmd_ready_s, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid.cmd_ready_after", cmd_ready_s, 1'b1);
    repeat (6) @(negedge clk);
    check("rst_mid.no_rsp", rsp_valid_s, 1'b0);
    check_reg("rst_mid.r1", 2'd1, 4'h0);
    check_reg("rst_mid.r0", 2'd0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
